mux_bus_responder: RTL and testbench

MUX_BUS_RESPONDER -- requirements
Module: mux_bus_responder

---
 rtl/mux_bus_responder.sv | 145 ++++++++++++++
 tb/tb_mux_bus_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_bus_responder.sv
// Responder for a phase-multiplexed 8-bit CPU bus backed by a 32 x 8 RAM at 0x0000-0x001F.
// Optional MUXBUS_WRITE_PROTECT_EN makes bus writes to 0x0010-0x001F read-only (preload still allowed).
module mux_bus_responder (
   input  logic        clk,
   input  logic        rst,
   input  logic        phase,
   input  logic [7:0]  addr_byte,
   input  logic [7:0]  bus_in,
   input  logic        load_en,
   input  logic [4:0]  load_addr,
   input  logic [7:0]  load_data,
   output logic [7:0]  data_out,
   output logic        data_valid,
   output logic        txn_done,
   output logic [15:0] last_addr,
   output logic        hit
);

   typedef enum logic [1:0] {SYNC, LO, HI} state_t;

   state_t      state_q, state_d;
   logic        phase_q, phase_d;
   logic [7:0]  addr_lo_q, addr_lo_d;
   logic [7:0]  addr_hi_q, addr_hi_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        rw_q, rw_d;
   logic [7:0]  data_out_q, data_out_d;
   logic        data_valid_q, data_valid_d;
   logic        txn_done_q, txn_done_d;
   logic [15:0] last_addr_q, last_addr_d;
   logic        hit_q, hit_d;
   logic [7:0]  mem_q [32];
   logic [7:0]  mem_d [32];

   logic        rise, fall, complete, in_window, wr_blocked, bus_we;
   logic [15:0] txn_addr;

   assign rise      = phase & ~phase_q;
   assign fall      = ~phase & phase_q;
   assign txn_addr  = {addr_hi_q, addr_lo_q};
   assign in_window = (txn_addr[15:5] == 11'd0);
   assign complete  = (state_q == HI) && fall;

`ifdef MUXBUS_WRITE_PROTECT_EN
   assign wr_blocked = txn_addr[4];
`else
   assign wr_blocked = 1'b0;
`endif

   assign bus_we = complete & ~rw_q & in_window & ~wr_blocked & ~rst;

   always_comb begin
      state_d      = state_q;
      phase_d      = phase;
      addr_lo_d    = addr_lo_q;
      addr_hi_d    = addr_hi_q;
      wdata_d      = wdata_q;
      rw_d         = rw_q;
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q;
      txn_done_d   = 1'b0;
      last_addr_d  = last_addr_q;
      hit_d        = hit_q;

      case (state_q)
         SYNC: begin
            if (fall) state_d = LO;
         end
         LO: begin
            if (!phase) begin
               addr_lo_d = addr_byte;
               rw_d      = bus_in[0];
            end
            if (rise) state_d = HI;
         end
         HI: begin
            if (phase) begin
               addr_hi_d = addr_byte;
               wdata_d   = bus_in;
            end else if (fall) begin
               // Completion uses the halves latched before this edge; the new low half is captured alongside.
               state_d     = LO;
               addr_lo_d   = addr_byte;
               rw_d        = bus_in[0];
               txn_done_d  = 1'b1;
               last_addr_d = txn_addr;
               hit_d       = in_window;
               if (rw_q) begin
                  data_valid_d = 1'b1;
                  data_out_d   = in_window ? mem_q[addr_lo_q[4:0]] : 8'hEA;
               end else begin
                  data_valid_d = 1'b0;
               end
            end
         end
         default: state_d = SYNC;
      endcase
   end

   // Preload is applied after the bus write so it wins on a same-entry collision.
   always_comb begin
      mem_d = mem_q;
      if (bus_we) mem_d[addr_lo_q[4:0]] = wdata_q;
      if (load_en) mem_d[load_addr] = load_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= SYNC;
         phase_q      <= 1'b1;
         addr_lo_q    <= 8'h00;
         addr_hi_q    <= 8'h00;
         wdata_q      <= 8'h00;
         rw_q         <= 1'b1;
         data_out_q   <= 8'h00;
         data_valid_q <= 1'b0;
         txn_done_q   <= 1'b0;
         last_addr_q  <= 16'h0000;
         hit_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         addr_lo_q    <= addr_lo_d;
         addr_hi_q    <= addr_hi_d;
         wdata_q      <= wdata_d;
         rw_q         <= rw_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         txn_done_q   <= txn_done_d;
         last_addr_q  <= last_addr_d;
         hit_q        <= hit_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign txn_done   = txn_done_q;
   assign last_addr  = last_addr_q;
   assign hit        = hit_q;

endmodule

// File: tb/tb_mux_bus_responder.sv
// Self-checking bench for mux_bus_responder: directed scenarios then randomized transactions
// checked against a transaction-level model of the RAM and output registers.
module tb_mux_bus_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        phase;
   logic [7:0]  addr_byte;
   logic [7:0]  bus_in;
   logic        load_en;
   logic [4:0]  load_addr;
   logic [7:0]  load_data;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        txn_done;
   logic [15:0] last_addr;
   logic        hit;

   always #5 clk = ~clk;

   mux_bus_responder dut (
      .clk        (clk),
      .rst        (rst),
      .phase      (phase),
      .addr_byte  (addr_byte),
      .bus_in     (bus_in),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .data_out   (data_out),
      .data_valid (data_valid),
      .txn_done   (txn_done),
      .last_addr  (last_addr),
      .hit        (hit)
   );

   int pass_cnt   = 0;
   int check_cnt  = 0;
   int pulse_cnt  = 0;
   int exp_pulses = 0;

   logic [7:0]  ram_m [32];
   logic [7:0]  exp_data;
   logic        exp_valid;
   logic        exp_hit;
   logic [15:0] exp_last;

   // One comparison point: counts it and reports any disagreement.
   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      check_cnt++;
      assert (obs === expv) pass_cnt++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Advance to the next falling edge, tallying any completion pulse seen there.
   task automatic step();
      @(negedge clk);
      if (txn_done === 1'b1) pulse_cnt++;
   endtask

   task automatic modelReset();
      exp_data  = 8'h00;
      exp_valid = 1'b0;
      exp_hit   = 1'b0;
      exp_last  = 16'h0000;
   endtask

   // Effect of one completed transaction on the outputs and RAM, straight from the address map rules.
   task automatic modelTxn(input logic [15:0] a, input logic rd, input logic [7:0] wd,
                           input logic ld_en, input logic [4:0] ld_a, input logic [7:0] ld_d);
      logic win;
      win = (a < 16'h0020);
      exp_pulses++;
      exp_last = a;
      exp_hit  = win;
      if (rd) begin
         exp_valid = 1'b1;
         exp_data  = win ? ram_m[a[4:0]] : 8'hEA;
      end else begin
         exp_valid = 1'b0;
         if (win) begin
`ifdef MUXBUS_WRITE_PROTECT_EN
            if (a < 16'h0010) ram_m[a[4:0]] = wd;
`else
            ram_m[a[4:0]] = wd;
`endif
         end
      end
      if (ld_en) ram_m[ld_a] = ld_d;
   endtask

   task automatic preload(input logic [4:0] ad, input logic [7:0] d);
      step();
      load_en   = 1'b1;
      load_addr = ad;
      load_data = d;
      ram_m[ad] = d;
      step();
      load_en = 1'b0;
   endtask

   // Drives low half, high half, then the falling-phase cycle (with optional preload); returns after completion edge.
   task automatic applyStimulus(input logic [15:0] a, input logic rd, input logic [7:0] wd,
                                input int nlo, input int nhi,
                                input logic ld_en, input logic [4:0] ld_a, input logic [7:0] ld_d);
      for (int i = 0; i < nlo; i++) begin
         step();
         phase     = 1'b0;
         addr_byte = a[7:0];
         bus_in    = {7'b0, rd};
      end
      for (int i = 0; i < nhi; i++) begin
         step();
         phase     = 1'b1;
         addr_byte = a[15:8];
         bus_in    = wd;
      end
      step();
      phase     = 1'b0;
      addr_byte = 8'h00;
      bus_in    = 8'h01;
      load_en   = ld_en;
      load_addr = ld_a;
      load_data = ld_d;
      step();
      load_en = 1'b0;
   endtask

   task automatic checkOutput(input string tag);
      checkValue({tag, "_txn_done"},   32'(txn_done),   32'd1);
      checkValue({tag, "_last_addr"},  32'(last_addr),  32'(exp_last));
      checkValue({tag, "_hit"},        32'(hit),        32'(exp_hit));
      checkValue({tag, "_data_valid"}, 32'(data_valid), 32'(exp_valid));
      checkValue({tag, "_data_out"},   32'(data_out),   32'(exp_data));
      checkValue({tag, "_pulses"},     32'(pulse_cnt),  32'(exp_pulses));
   endtask

   task automatic checkResetOutputs(input string tag);
      checkValue({tag, "_data_out"},   32'(data_out),   32'd0);
      checkValue({tag, "_data_valid"}, 32'(data_valid), 32'd0);
      checkValue({tag, "_txn_done"},   32'(txn_done),   32'd0);
      checkValue({tag, "_last_addr"},  32'(last_addr),  32'd0);
      checkValue({tag, "_hit"},        32'(hit),        32'd0);
   endtask

   task automatic doReset(input logic ph, input int n);
      step();
      rst     = 1'b1;
      phase   = ph;
      load_en = 1'b0;
      for (int i = 1; i < n; i++) step();
      step();
      modelReset();
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] ra;
      logic        rrd;
      logic [7:0]  rwd;
      logic        rld;
      logic [4:0]  rla;
      int          nlo, nhi;

      rst       = 1'b1;
      phase     = 1'b0;
      addr_byte = 8'h00;
      bus_in    = 8'h00;
      load_en   = 1'b0;
      load_addr = 5'd0;
      load_data = 8'h00;
      modelReset();
      step(); step(); step();
      checkResetOutputs("reset");

      step();
      rst = 1'b0;
      step();

      for (int i = 0; i < 32; i++) preload(5'(i), 8'($urandom));
      preload(5'd5, 8'h3C);
      preload(5'd18, 8'h5A);

      applyStimulus(16'h0005, 1'b1, 8'h00, 2, 2, 1'b0, 5'd0, 8'h00);
      modelTxn(16'h0005, 1'b1, 8'h00, 1'b0, 5'd0, 8'h00);
      checkOutput("rd0005");
      checkValue("rd0005_literal", 32'(data_out), 32'h3C);

      applyStimulus(16'h0012, 1'b0, 8'hA5, 2, 2, 1'b0, 5'd0, 8'h00);
      modelTxn(16'h0012, 1'b0, 8'hA5, 1'b0, 5'd0, 8'h00);
      checkOutput("wr0012");
      applyStimulus(16'h0012, 1'b1, 8'h00, 1, 3, 1'b0, 5'd0, 8'h00);
      modelTxn(16'h0012, 1'b1, 8'h00, 1'b0, 5'd0, 8'h00);
      checkOutput("rd0012");
`ifdef MUXBUS_WRITE_PROTECT_EN
      checkValue("rd0012_literal", 32'(data_out), 32'h5A);
`else
      checkValue("rd0012_literal", 32'(data_out), 32'hA5);
`endif

      applyStimulus(16'h1234, 1'b1, 8'h00, 2, 2, 1'b0, 5'd0, 8'h00);
      modelTxn(16'h1234, 1'b1, 8'h00, 1'b0, 5'd0, 8'h00);
      checkOutput("rd1234");
      checkValue("rd1234_literal", 32'(data_out), 32'hEA);

      applyStimulus(16'h0407, 1'b0, 8'h77, 2, 2, 1'b0, 5'd0, 8'h00);
      modelTxn(16'h0407, 1'b0, 8'h77, 1'b0, 5'd0, 8'h00);
      checkOutput("wr0407");
      applyStimulus(16'h0020, 1'b0, 8'h66, 3, 2, 1'b0, 5'd0, 8'h00);
      modelTxn(16'h0020, 1'b0, 8'h66, 1'b0, 5'd0, 8'h00);
      checkOutput("wr0020");
      applyStimulus(16'h0000, 1'b1, 8'h00, 2, 2, 1'b0, 5'd0, 8'h00);
      modelTxn(16'h0000, 1'b1, 8'h00, 1'b0, 5'd0, 8'h00);
      checkOutput("rd0000");

      applyStimulus(16'h0007, 1'b0, 8'h22, 2, 2, 1'b1, 5'd7, 8'h11);
      modelTxn(16'h0007, 1'b0, 8'h22, 1'b1, 5'd7, 8'h11);
      checkOutput("wr0007_load");
      applyStimulus(16'h0007, 1'b1, 8'h00, 2, 2, 1'b0, 5'd0, 8'h00);
      modelTxn(16'h0007, 1'b1, 8'h00, 1'b0, 5'd0, 8'h00);
      checkOutput("rd0007");
      checkValue("rd0007_literal", 32'(data_out), 32'h11);

      preload(5'd9, 8'h3F);
      applyStimulus(16'h0009, 1'b1, 8'h00, 2, 2, 1'b1, 5'd9, 8'hC3);
      modelTxn(16'h0009, 1'b1, 8'h00, 1'b1, 5'd9, 8'hC3);
      checkOutput("rd0009_load");
      checkValue("rd0009_preload_literal", 32'(data_out), 32'h3F);
      applyStimulus(16'h0009, 1'b1, 8'h00, 2, 2, 1'b0, 5'd0, 8'h00);
      modelTxn(16'h0009, 1'b1, 8'h00, 1'b0, 5'd0, 8'h00);
      checkOutput("rd0009_after");
      checkValue("rd0009_after_literal", 32'(data_out), 32'hC3);

      // A one-clock high half never reaches the high-capture state, so the prior high byte (0x00) is used.
      applyStimulus(16'h7705, 1'b1, 8'h00, 2, 1, 1'b0, 5'd0, 8'h00);
      modelTxn(16'h0005, 1'b1, 8'h00, 1'b0, 5'd0, 8'h00);
      checkOutput("pulse1");

      // Reset during the high half of a write to 0x0003 must abort it.
      for (int i = 0; i < 2; i++) begin
         step();
         phase     = 1'b0;
         addr_byte = 8'h03;
         bus_in    = 8'h00;
      end
      for (int i = 0; i < 2; i++) begin
         step();
         phase     = 1'b1;
         addr_byte = 8'h00;
         bus_in    = 8'h99;
      end
      doReset(1'b1, 2);
      checkResetOutputs("midrst");
      checkValue("midrst_pulses", 32'(pulse_cnt), 32'(exp_pulses));
      rst       = 1'b0;
      phase     = 1'b0;
      addr_byte = 8'h00;
      bus_in    = 8'h01;
      step();
      applyStimulus(16'h0003, 1'b1, 8'h00, 2, 2, 1'b0, 5'd0, 8'h00);
      modelTxn(16'h0003, 1'b1, 8'h00, 1'b0, 5'd0, 8'h00);
      checkOutput("rd0003_after_rst");

      // phase held high through release: the first low cycle only leaves SYNC, so reset lo/rw values are used.
      doReset(1'b1, 2);
      rst = 1'b0;
      step(); step(); step();
      checkValue("sync_hold_pulses", 32'(pulse_cnt), 32'(exp_pulses));
      checkValue("sync_hold_valid", 32'(data_valid), 32'd0);
      applyStimulus(16'h0005, 1'b0, 8'hF0, 1, 2, 1'b0, 5'd0, 8'h00);
      modelTxn(16'h0000, 1'b1, 8'h00, 1'b0, 5'd0, 8'h00);
      checkOutput("sync_first");

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(1, 0) == 1) ra = {11'd0, 5'($urandom)};
         else ra = 16'($urandom);
         rrd = 1'($urandom);
         rwd = 8'($urandom);
         nlo = int'($urandom_range(3, 1));
         nhi = int'($urandom_range(4, 2));
         rld = ($urandom_range(3, 0) == 0);
         rla = ($urandom_range(1, 0) == 1) ? ra[4:0] : 5'($urandom);
         applyStimulus(ra, rrd, rwd, nlo, nhi, rld, rla, 8'(n * 7 + 1));
         modelTxn(ra, rrd, rwd, rld, rla, 8'(n * 7 + 1));
         checkOutput($sformatf("rand%0d", n));
      end

      step(); step();
      checkValue("final_pulses", 32'(pulse_cnt), 32'(exp_pulses));

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
